apb_slave_mem: RTL
==================

Name: apb_slave_mem

Overview:
- RTL APB4 completer (slave DUT) backed by a byte-lane memory.
- Sits directly downstream of the master agent's pin-level interface and consumes the transfers it drives: paddr, pwrite, pwdata, pstrb, pprot, pselx.
- Provides configurable wait-state insertion and pslverr generation.
- Sized from the shared global package constants (12 KB memory, 32-bit data, 8-bit storage width).

Parameters:
- ADDRESS_WIDTH, 32, paddr width.
- DATA_WIDTH, 32, pwdata/prdata width; must be 32.
- MEM_KB, 12, memory size in KB; defaults to SLAVE_MEMORY_SIZE.
- BASE_ADDR, 32'h0000_0000, first byte address decoded by this slave.
- SECURE_ONLY, 0, when 1, non-secure accesses (pprot[1]=1) are rejected.

Ports:
- pclk  in  1  APB clock
- preset  in  1  synchronous active-high reset
- psel  in  1  select (this slave's bit of pselx)
- penable  in  1  access phase
- pwrite  in  1  1=WRITE, 0=READ (tx_type_e)
- paddr  in  ADDRESS_WIDTH  byte address
- pwdata  in  DATA_WIDTH  write data
- pstrb  in  DATA_WIDTH/8  write byte strobes
- pprot  in  3  protection (protection_type_e)
- wait_cfg  in  4  wait states to insert per transfer (0-15)
- pready  out  1  transfer complete
- pslverr  out  1  error response, valid only with pready
- prdata  out  DATA_WIDTH  read data, valid only with pready & !pwrite

Behaviour:
- Reset: one clock, pclk. Reset is synchronous and active-high (preset). While preset=1 at a pclk edge:
  - state=IDLE, pready=0, pslverr=0, prdata=0, wait counter=0.
  - Memory contents are not cleared.
  - A transfer in flight is abandoned and no write is committed.
- FSM states are IDLE, WAIT and READY, defined as apb_slave_state_e.
- IDLE:
  - On setup (psel=1, penable=0), sample wait_cfg and the error condition.
  - wait_cfg=0: go to READY.
  - Otherwise: load cnt=wait_cfg and go to WAIT.
  - All other inputs: stay in IDLE.
- WAIT:
  - pready=0.
  - If psel=0 (aborted transfer): go to IDLE, no write.
  - Else if cnt=1: go to READY.
  - Else decrement cnt.
  - Net effect: exactly wait_cfg access cycles with pready=0.
- READY:
  - pready=1 for exactly one cycle; pslverr carries the latched error.
  - Next state is IDLE.
  - A back-to-back setup is accepted in the following cycle, so there are no idle bubbles beyond the APB minimum.
- Latency: pready rises in access cycle wait_cfg+1, counting the first penable=1 cycle as 1. Outputs are registered.
- Error condition, evaluated in the setup cycle; any one sets the error:
  - paddr < BASE_ADDR.
  - paddr > BASE_ADDR + MEM_KB*1024 - 4.
  - paddr[1:0] != 0.
  - SECURE_ONLY=1 and pprot[1]=1.
- Write: committed at the pclk edge ending the READY cycle, only if psel & penable & pwrite & !error. Byte lane i is written only when pstrb[i]=1. Byte index = paddr - BASE_ADDR + i, little-endian.
- Read: prdata is loaded on entry to READY with the 4 bytes at the word index. prdata=0 when error, when pwrite=1, and in IDLE/WAIT.
- pstrb is ignored on reads.
- pslverr=0 whenever pready=0.
- Address arithmetic is done in ADDRESS_WIDTH+1 bits so BASE_ADDR + size cannot wrap.
- The last valid word is BASE_ADDR + 0x2FFC (default sizing).
- wait_cfg changes mid-transfer have no effect until the next setup.

Decomposition:
- Add to the global package (apb_global_pkg):
  - apb_slave_state_e {IDLE, WAIT, READY}, 2 bits.
  - SLAVE_BASE_ADDRESS constant.
  - MEM_BYTES = SLAVE_MEMORY_SIZE*1024.
- Reuse tx_type_e and protection_type_e from the same package.
- One sub-module: apb_slave_mem_array. It is a MEM_BYTES x MEMORY_WIDTH array with:
  - a 4-lane byte-enable synchronous write port;
  - a combinational 32-bit read port;
  - word index input of $clog2(MEM_BYTES)-2 bits.
- The FSM, decode and error logic live in apb_slave_mem.

Test Plan:
- Zero-wait write/read, wait_cfg=0: write 0xDEADBEEF to 0x10 with pstrb=0xF, then read 0x10 → pready in the first access cycle both times, prdata=0xDEADBEEF, pslverr=0.
- Wait states, wait_cfg=3: read 0x20 → pready=0 for 3 access cycles, high on the 4th, for exactly one cycle.
- Strobes: write 0xFFFFFFFF to 0x40, then write 0x11223344 with pstrb=0b0101 → read returns 0xFF22FF44.
- Errors:
  - write to 0x3000 → pslverr=1 with pready.
  - read 0x2FFC → pslverr=0.
  - read 0x42 → pslverr=1, prdata=0.
  - memory at 0x3000-adjacent words unchanged.
- SECURE_ONLY=1: write with pprot=3'b010 → pslverr=1 and memory unchanged; the same write with pprot=3'b000 succeeds.
- Reset/abort:
  - assert preset during WAIT (wait_cfg=5) → next cycle pready=0, state IDLE, and the target word keeps its old value.
  - drop psel mid-WAIT → FSM returns to IDLE and no write occurs.

Source files
------------

// File: rtl/apb_global_pkg.sv
// Shared APB constants and types.
//   SLAVE_MEMORY_SIZE  : slave memory size in KB
//   MEMORY_WIDTH       : storage element width in bits
//   SLAVE_BASE_ADDRESS : first byte address decoded by the slave
//   MEM_BYTES          : slave memory size in bytes
//   tx_type_e, protection_type_e, apb_slave_state_e
package apb_global_pkg;

  localparam int unsigned SLAVE_MEMORY_SIZE  = 12;
  localparam int unsigned MEMORY_WIDTH       = 8;
  localparam logic [31:0] SLAVE_BASE_ADDRESS = 32'h0000_0000;
  localparam int unsigned MEM_BYTES          = SLAVE_MEMORY_SIZE * 1024;

  typedef enum logic {
    READ  = 1'b0,
    WRITE = 1'b1
  } tx_type_e;

  // pprot[0]=privileged, pprot[1]=non-secure, pprot[2]=instruction
  typedef enum logic [2:0] {
    NORMAL_SECURE_DATA            = 3'b000,
    PRIVILEGED_SECURE_DATA        = 3'b001,
    NORMAL_NONSECURE_DATA         = 3'b010,
    PRIVILEGED_NONSECURE_DATA     = 3'b011,
    NORMAL_SECURE_INSTR           = 3'b100,
    PRIVILEGED_SECURE_INSTR       = 3'b101,
    NORMAL_NONSECURE_INSTR        = 3'b110,
    PRIVILEGED_NONSECURE_INSTR    = 3'b111
  } protection_type_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    READY = 2'd2
  } apb_slave_state_e;

endpackage

// File: rtl/apb_slave_mem_if.sv
// APB4 completer-side bus bundle.
//   master modport : drives psel/penable/pwrite/paddr/pwdata/pstrb/pprot
//   slave modport  : drives pready/pslverr/prdata
interface apb_slave_mem_if #(
  parameter int unsigned ADDRESS_WIDTH = 32,
  parameter int unsigned DATA_WIDTH    = 32
);

  logic                      psel;
  logic                      penable;
  logic                      pwrite;
  logic [ADDRESS_WIDTH-1:0]  paddr;
  logic [DATA_WIDTH-1:0]     pwdata;
  logic [DATA_WIDTH/8-1:0]   pstrb;
  logic [2:0]                pprot;
  logic                      pready;
  logic                      pslverr;
  logic [DATA_WIDTH-1:0]     prdata;

  modport master (
    output psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
    input  pready, pslverr, prdata
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
    output pready, pslverr, prdata
  );

endinterface

// File: rtl/apb_slave_mem_array.sv
// Byte-lane memory for the APB slave.
//   clk   : write clock
//   we    : write enable (word)
//   be    : per-byte write enables, lane i = bits [8i+7:8i]
//   idx   : word index (shared by read and write)
//   wdata : write data
//   rdata : combinational read data of word idx, little-endian
module apb_slave_mem_array
  import apb_global_pkg::*;
#(
  parameter int unsigned DEPTH_BYTES = MEM_BYTES
) (
  input  logic                            clk,
  input  logic                            we,
  input  logic [3:0]                      be,
  input  logic [$clog2(DEPTH_BYTES)-3:0]  idx,
  input  logic [4*MEMORY_WIDTH-1:0]       wdata,
  output logic [4*MEMORY_WIDTH-1:0]       rdata
);

  logic [MEMORY_WIDTH-1:0] mem [DEPTH_BYTES];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (be[i]) begin
          mem[{idx, i[1:0]}] <= wdata[i*MEMORY_WIDTH +: MEMORY_WIDTH];
        end
      end
    end
  end

  always_comb begin
    rdata = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      rdata[i*MEMORY_WIDTH +: MEMORY_WIDTH] = mem[{idx, i[1:0]}];
    end
  end

endmodule

// File: rtl/apb_slave_mem.sv
// APB4 completer backed by a byte-lane memory.
//   pclk     : APB clock
//   preset   : synchronous active-high reset
//   bus      : APB slave modport (psel, penable, pwrite, paddr, pwdata,
//              pstrb, pprot in; pready, pslverr, prdata out)
//   wait_cfg : wait states inserted per transfer, sampled in setup
module apb_slave_mem
  import apb_global_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH = 32,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned MEM_KB        = SLAVE_MEMORY_SIZE,
  parameter logic [31:0] BASE_ADDR     = SLAVE_BASE_ADDRESS,
  parameter bit          SECURE_ONLY   = 1'b0
) (
  input  logic                pclk,
  input  logic                preset,
  apb_slave_mem_if.slave      bus,
  input  logic [3:0]          wait_cfg
);

  localparam int unsigned BYTES = MEM_KB * 1024;
  localparam int unsigned IDX_W = $clog2(BYTES) - 2;
  localparam logic [ADDRESS_WIDTH:0] BASE_EXT = (ADDRESS_WIDTH+1)'(BASE_ADDR);
  localparam logic [ADDRESS_WIDTH:0] LAST_EXT = BASE_EXT + (ADDRESS_WIDTH+1)'(BYTES - 4);

  apb_slave_state_e        state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic                    err_q, err_d;
  logic                    pready_q, pslverr_q;
  logic [DATA_WIDTH-1:0]   prdata_q, prdata_d;

  logic [ADDRESS_WIDTH:0]  addr_ext, offset;
  logic [IDX_W-1:0]        word_idx;
  logic                    below_base, addr_err, nonsecure;
  logic                    mem_we, entering_ready;
  logic [DATA_WIDTH-1:0]   mem_rdata;
  protection_type_e        prot;

  // Extra bit keeps BASE + size from wrapping; the borrow out of the
  // subtraction (top bit of offset) flags addresses below BASE_ADDR.
  assign addr_ext   = {1'b0, bus.paddr};
  assign offset     = addr_ext - BASE_EXT;
  assign below_base = offset[ADDRESS_WIDTH];
  assign word_idx   = offset[IDX_W+1:2];

  assign prot      = protection_type_e'(bus.pprot);
  assign nonsecure = prot[1];

  assign addr_err = below_base
                 || (addr_ext > LAST_EXT)
                 || (bus.paddr[1:0] != 2'b00)
                 || (SECURE_ONLY && nonsecure);

  logic unused_ok;
  assign unused_ok = ^{offset[ADDRESS_WIDTH-1:IDX_W+2], offset[1:0], prot[2], prot[0]};

  // Commit at the edge ending READY; reset at that edge suppresses it.
  assign mem_we = (state_q == READY) && bus.psel && bus.penable
               && (bus.pwrite == WRITE) && !err_q && !preset;

  apb_slave_mem_array #(
    .DEPTH_BYTES (BYTES)
  ) u_mem (
    .clk   (pclk),
    .we    (mem_we),
    .be    (bus.pstrb),
    .idx   (word_idx),
    .wdata (bus.pwdata),
    .rdata (mem_rdata)
  );

  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      pready_q  <= entering_ready;
      pslverr_q <= entering_ready && err_d;
      prdata_q  <= prdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (bus.psel && !bus.penable) begin
          err_d = addr_err;
          if (wait_cfg == 4'd0) begin
            state_d = READY;
          end else begin
            cnt_d   = wait_cfg;
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (!bus.psel) begin
          state_d = IDLE;
        end else if (cnt_q == 4'd1) begin
          state_d = READY;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      READY:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next state so pready appears in the
  // first cycle of READY rather than one cycle later.
  always_comb begin
    entering_ready = (state_d == READY);
    prdata_d       = '0;
    if (entering_ready && !err_d && (bus.pwrite == READ)) begin
      prdata_d = mem_rdata;
    end
  end

  assign bus.pready  = pready_q;
  assign bus.pslverr = pslverr_q;
  assign bus.prdata  = prdata_q;

endmodule
